// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for a bank of common-cathode
//               7-segment digits sharing one 4511-style BCD decoder.
//               Runs a lamp test after reset, then per digit: blank (D loaded
//               into the decoder latch) -> show (latch held, digit enabled),
//               round-robin from digit 0 (least significant) upward.
// Ports       : clk           system clock, rising edge
//               rst_n         synchronous active-low reset
//               bcd_in_i      packed BCD, digit i = bcd_in_i[4i+3:4i]
//               load_i        1-cycle strobe, capture bcd_in_i as pending frame
//               zs_en_i       leading-zero suppression enable
//               d_o           BCD nibble to decoder
//               le_o          decoder latch enable (1 = hold)
//               bl_o          decoder blank, active low
//               lt_o          decoder lamp test, active low
//               dig_sel_o     one-hot digit enable, active high
//               frame_tick_o  1-cycle pulse when the scan wraps to digit 0
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int DWELL     = 1000,
    parameter int BLANK_CYC = 8,
    parameter int LT_CYC    = 5000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in_i,
    input  logic                  load_i,
    input  logic                  zs_en_i,
    output logic [3:0]            d_o,
    output logic                  le_o,
    output logic                  bl_o,
    output logic                  lt_o,
    output logic [DIGITS-1:0]     dig_sel_o,
    output logic                  frame_tick_o
);

    // Counter must span the longest phase.
    localparam int c_cnt_max = (LT_CYC > DWELL)
                             ? ((LT_CYC > BLANK_CYC) ? LT_CYC : BLANK_CYC)
                             : ((DWELL > BLANK_CYC) ? DWELL : BLANK_CYC);
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_cnt_w-1:0] c_lt_last    = c_cnt_w'(LT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL - 1);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_LAMP  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [c_cnt_w-1:0]    cnt_q,     cnt_d;
    logic [c_idx_w-1:0]    idx_q,     idx_d;
    logic [4*DIGITS-1:0]   active_q,  active_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic                  pend_v_q,  pend_v_d;
    logic [3:0]            d_q,       d_d;
    logic                  le_q,      le_d;
    logic                  bl_q,      bl_d;
    logic                  lt_q,      lt_d;
    logic [DIGITS-1:0]     dig_q,     dig_d;
    logic                  ft_q,      ft_d;
    logic                  w_commit;
    logic                  w_supp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_LAMP;
            cnt_q     <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            pending_q <= '0;
            pend_v_q  <= 1'b0;
            d_q       <= 4'd0;
            le_q      <= 1'b0;
            bl_q      <= 1'b0;
            lt_q      <= 1'b1;
            dig_q     <= '0;
            ft_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            d_q       <= d_d;
            le_q      <= le_d;
            bl_q      <= bl_d;
            lt_q      <= lt_d;
            dig_q     <= dig_d;
            ft_q      <= ft_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        active_d  = active_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        w_commit  = 1'b0;

        unique case (state_q)
            ST_LAMP: begin
                // lt_q still high means the reset values are on the pins:
                // this edge opens the first lamp-test cycle.
                if (lt_q) begin
                    cnt_d = '0;
                end else if (cnt_q == c_lt_last) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_BLANK: begin
                if (cnt_q == c_blank_last) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == c_dwell_last) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == c_idx_last) begin
                        idx_d    = '0;
                        w_commit = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_LAMP;
                cnt_d   = '0;
            end
        endcase

        // The displayed frame only changes at the wrap, so a frame is never torn.
        if (w_commit) begin
            if (load_i) begin
                active_d = bcd_in_i;
            end else if (pend_v_q) begin
                active_d = pending_q;
            end
            pend_v_d = 1'b0;
        end else if (load_i) begin
            pending_d = bcd_in_i;
            pend_v_d  = 1'b1;
        end

        // Leading-zero suppression: this digit and every higher digit are zero.
        w_supp = zs_en_i && (idx_d != '0);
        for (int j = 0; j < DIGITS; j++) begin
            if ((j >= int'(idx_d)) && (active_d[4*j +: 4] != 4'd0)) begin
                w_supp = 1'b0;
            end
        end

        // Outputs are registered from the next state (Moore, one cycle aligned).
        d_d   = d_q;
        le_d  = 1'b0;
        bl_d  = 1'b1;
        lt_d  = 1'b1;
        dig_d = '0;
        ft_d  = 1'b0;
        unique case (state_d)
            ST_LAMP: begin
                lt_d  = 1'b0;
                dig_d = '1;
            end
            ST_BLANK: begin
                bl_d = 1'b0;
                d_d  = active_d[4*idx_d +: 4];
                ft_d = w_commit;
            end
            ST_SHOW: begin
                le_d  = 1'b1;
                bl_d  = ~w_supp;
                dig_d = w_supp ? '0 : (DIGITS'(1) << idx_d);
            end
            default: begin
                lt_d = 1'b1;
            end
        endcase
    end

    assign d_o          = d_q;
    assign le_o         = le_q;
    assign bl_o         = bl_q;
    assign lt_o         = lt_q;
    assign dig_sel_o    = dig_q;
    assign frame_tick_o = ft_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl. A time-based reference
//               model derives every output from the cycle count since reset
//               release; directed scenarios pin the model with literal values,
//               then randomized loads, zero-suppression toggles and resets run.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int DWELL     = 3;
    localparam int BLANK_CYC = 2;
    localparam int LT_CYC    = 5;
    localparam int P         = BLANK_CYC + DWELL;
    localparam int F         = DIGITS * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic        load = 1'b0;
    logic        zs_en = 1'b0;
    logic [3:0]  d_o;
    logic        le_o, bl_o, lt_o, ft_o;
    logic [3:0]  dig_o;

    int n_cmp  = 0;
    int n_fail = 0;

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .DWELL(DWELL), .BLANK_CYC(BLANK_CYC), .LT_CYC(LT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in_i(bcd_in), .load_i(load),
        .zs_en_i(zs_en), .d_o(d_o), .le_o(le_o), .bl_o(bl_o), .lt_o(lt_o),
        .dig_sel_o(dig_o), .frame_tick_o(ft_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_t = -1;
    logic        m_valid = 1'b0;
    logic [15:0] m_act = 16'h0, m_pend = 16'h0;
    logic        m_pv = 1'b0;
    logic [3:0]  e_d = 4'h0, e_dig = 4'h0;
    logic        e_le = 1'b0, e_bl = 1'b0, e_lt = 1'b1, e_ft = 1'b0;

    always @(posedge clk) begin
        int tp, f, slot, ph;
        logic supp;
        if (!rst_n) begin
            m_t = -1; m_valid = 1'b1;
            m_act = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
            e_d = 4'h0; e_le = 1'b0; e_bl = 1'b0; e_lt = 1'b1; e_dig = 4'h0; e_ft = 1'b0;
        end else if (m_valid) begin
            m_t = m_t + 1;
            e_ft = 1'b0;
            if (m_t < LT_CYC) begin
                e_lt = 1'b0; e_bl = 1'b1; e_le = 1'b0; e_dig = 4'hF; e_d = 4'h0;
                if (load) begin m_pend = bcd_in; m_pv = 1'b1; end
            end else begin
                tp   = m_t - LT_CYC;
                f    = tp % F;
                slot = f / P;
                ph   = f % P;
                if (f == 0 && tp > 0) begin
                    e_ft = 1'b1;
                    if (load) m_act = bcd_in;
                    else if (m_pv) m_act = m_pend;
                    m_pv = 1'b0;
                end else if (load) begin
                    m_pend = bcd_in; m_pv = 1'b1;
                end
                e_d  = m_act[4*slot +: 4];
                e_lt = 1'b1;
                if (ph < BLANK_CYC) begin
                    e_bl = 1'b0; e_le = 1'b0; e_dig = 4'h0;
                end else begin
                    supp  = zs_en && (slot != 0) && ((m_act >> (4*slot)) == 16'h0);
                    e_le  = 1'b1;
                    e_bl  = ~supp;
                    e_dig = supp ? 4'h0 : (4'b0001 << slot);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic       p_le = 1'b0;
    logic [3:0] p_d  = 4'h0;

    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if ({d_o, le_o, bl_o, lt_o, dig_o, ft_o} !== {e_d, e_le, e_bl, e_lt, e_dig, e_ft}) begin
                n_fail++;
                $display("FAIL model t=%0d act D=%h LE=%b BL=%b LT=%b SEL=%h FT=%b exp D=%h LE=%b BL=%b LT=%b SEL=%h FT=%b",
                         m_t, d_o, le_o, bl_o, lt_o, dig_o, ft_o, e_d, e_le, e_bl, e_lt, e_dig, e_ft);
            end
            if (lt_o) begin
                n_cmp++;
                if (!$onehot0(dig_o)) begin
                    n_fail++;
                    $display("FAIL onehot0 t=%0d act SEL=%h exp one-hot or zero", m_t, dig_o);
                end
            end
            if (le_o && p_le) begin
                n_cmp++;
                if (d_o !== p_d) begin
                    n_fail++;
                    $display("FAIL d_stable t=%0d act D=%h exp D=%h", m_t, d_o, p_d);
                end
            end
            p_le = le_o;
            p_d  = d_o;
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d act=%h exp=%h", name, m_t, act, exp);
        end
    endtask

    task automatic goto(input int t);
        int guard = 0;
        while (m_t != t && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("goto_reached", m_t, t);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        bcd_in = v;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_lt",  {31'd0, lt_o}, 32'd1);
        chk("rst_sel", {28'd0, dig_o}, 32'h0);
        rst_n = 1'b1;

        // 1: lamp test, first blank, first show
        goto(0);
        chk("lamp_lt",  {31'd0, lt_o}, 32'd0);
        chk("lamp_sel", {28'd0, dig_o}, 32'hF);
        goto(4);
        chk("lamp_end_lt", {31'd0, lt_o}, 32'd0);
        goto(5);
        chk("blank0_bl",  {31'd0, bl_o}, 32'd0);
        chk("blank0_sel", {28'd0, dig_o}, 32'h0);
        chk("blank0_ft",  {31'd0, ft_o}, 32'd0);
        goto(7);
        chk("show0_sel", {28'd0, dig_o}, 32'h1);
        chk("show0_le",  {31'd0, le_o}, 32'd1);

        // 2: mid-frame load appears only after wrap
        goto(10);
        pulse_load(16'h1234);
        goto(22);
        chk("no_tear_d", {28'd0, d_o}, 32'h0);
        goto(25);
        chk("wrap_ft", {31'd0, ft_o}, 32'd1);
        goto(27); chk("f2_d0", {28'd0, d_o}, 32'h4); chk("f2_s0", {28'd0, dig_o}, 32'h1);
        goto(32); chk("f2_d1", {28'd0, d_o}, 32'h3); chk("f2_s1", {28'd0, dig_o}, 32'h2);
        goto(37); chk("f2_d2", {28'd0, d_o}, 32'h2); chk("f2_s2", {28'd0, dig_o}, 32'h4);
        goto(42); chk("f2_d3", {28'd0, d_o}, 32'h1); chk("f2_s3", {28'd0, dig_o}, 32'h8);

        // 4: load in the commit cycle wins over an earlier pending load
        goto(50);
        pulse_load(16'h1111);
        goto(64);
        pulse_load(16'h5678);
        goto(67); chk("byp_d0", {28'd0, d_o}, 32'h8);
        goto(72); chk("byp_d1", {28'd0, d_o}, 32'h7);
        goto(77); chk("byp_d2", {28'd0, d_o}, 32'h6);
        goto(82); chk("byp_d3", {28'd0, d_o}, 32'h5);
        goto(87); chk("byp_keep", {28'd0, d_o}, 32'h8);

        // 3: leading-zero suppression
        goto(90);
        zs_en = 1'b1;
        pulse_load(16'h0070);
        goto(107); chk("zs_d0", {28'd0, d_o}, 32'h0); chk("zs_s0", {28'd0, dig_o}, 32'h1);
        goto(112); chk("zs_d1", {28'd0, d_o}, 32'h7); chk("zs_s1", {28'd0, dig_o}, 32'h2);
        goto(117); chk("zs_s2", {28'd0, dig_o}, 32'h0); chk("zs_bl2", {31'd0, bl_o}, 32'd0);
        goto(122); chk("zs_s3", {28'd0, dig_o}, 32'h0); chk("zs_bl3", {31'd0, bl_o}, 32'd0);
        goto(126);
        pulse_load(16'h0000);
        goto(147); chk("zs0_s0", {28'd0, dig_o}, 32'h1); chk("zs0_bl0", {31'd0, bl_o}, 32'd1);
        goto(152); chk("zs0_s1", {28'd0, dig_o}, 32'h0);

        // 5: reset during show of digit 2 discards pending data
        goto(160);
        zs_en = 1'b0;
        pulse_load(16'h9999);
        goto(177);
        chk("pre_rst_sel", {28'd0, dig_o}, 32'h4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_lt",  {31'd0, lt_o}, 32'd1);
        chk("mid_rst_sel", {28'd0, dig_o}, 32'h0);
        chk("mid_rst_le",  {31'd0, le_o}, 32'd0);
        rst_n = 1'b1;
        goto(0);
        chk("relamp_sel", {28'd0, dig_o}, 32'hF);
        goto(27);
        chk("discard_d", {28'd0, d_o}, 32'h0);

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bcd_in = 16'($urandom);
            load   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 39) == 0) zs_en = ~zs_en;
            rst_n  = ($urandom_range(0, 699) != 0);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
